// File: rtl/trans_id_scoreboard.sv
// -----------------------------------------------------------------------------
// trans_id_scoreboard
//   Circular-buffer scoreboard that hands out transaction IDs in issue order,
//   accepts out-of-order results on NR_WB_PORTS writeback ports and retires
//   entries strictly in order from the head.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             discard every outstanding entry
//   issue_valid_i/rd_i  allocate the tail entry for destination register rd
//   issue_trans_id_o    ID that an issue this cycle receives (tail pointer)
//   full_o              no free entry; issues are refused
//   wb_valid_i/..._i    per-port writeback strobe, target ID, data, exception
//   commit_*_o          head entry result, valid when the head is done
//   commit_ack_i        retire the head entry
//
// Configuration
//   SCOREBOARD_WB_BYPASS_EN  when defined, a writeback to the not-yet-done head
//                            entry is forwarded to the commit outputs in the
//                            same cycle so it can retire with zero latency.
// -----------------------------------------------------------------------------
module trans_id_scoreboard #(
    parameter int unsigned NR_ENTRIES  = 8,
    parameter int unsigned NR_WB_PORTS = 4,
    parameter int unsigned DATA_W      = 64,
    localparam int unsigned TID_W      = $clog2(NR_ENTRIES)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            issue_valid_i,
    input  logic [4:0]                      issue_rd_i,
    output logic [TID_W-1:0]                issue_trans_id_o,
    output logic                            full_o,
    input  logic [NR_WB_PORTS-1:0]          wb_valid_i,
    input  logic [NR_WB_PORTS*TID_W-1:0]    wb_trans_id_i,
    input  logic [NR_WB_PORTS*DATA_W-1:0]   wb_data_i,
    input  logic [NR_WB_PORTS-1:0]          wb_ex_i,
    output logic                            commit_valid_o,
    output logic [4:0]                      commit_rd_o,
    output logic [DATA_W-1:0]               commit_data_o,
    output logic                            commit_ex_o,
    input  logic                            commit_ack_i
);

    localparam int unsigned CNT_W = TID_W + 1;

    logic [TID_W-1:0]  tail_q, tail_d, head_q, head_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              issued_q [NR_ENTRIES];
    logic              issued_d [NR_ENTRIES];
    logic              done_q   [NR_ENTRIES];
    logic              done_d   [NR_ENTRIES];
    logic [4:0]        rd_q     [NR_ENTRIES];
    logic [4:0]        rd_d     [NR_ENTRIES];
    logic [DATA_W-1:0] data_q   [NR_ENTRIES];
    logic [DATA_W-1:0] data_d   [NR_ENTRIES];
    logic              ex_q     [NR_ENTRIES];
    logic              ex_d     [NR_ENTRIES];

    logic              wb_hit_s  [NR_ENTRIES];
    logic [DATA_W-1:0] wb_data_s [NR_ENTRIES];
    logic              wb_ex_s   [NR_ENTRIES];
    logic              issue_acc_s;
    logic              commit_fire_s;

    assign full_o           = (cnt_q == CNT_W'(NR_ENTRIES));
    assign issue_trans_id_o = tail_q;
    assign issue_acc_s      = issue_valid_i & ~full_o;
    assign commit_fire_s    = commit_valid_o & commit_ack_i;

    // Per-entry writeback selection; ports are scanned high to low so the
    // lowest-index matching port is the one left standing.
    always_comb begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            wb_hit_s[e]  = 1'b0;
            wb_data_s[e] = '0;
            wb_ex_s[e]   = 1'b0;
            for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_trans_id_i[p*TID_W +: TID_W] == TID_W'(e))) begin
                    wb_hit_s[e]  = 1'b1;
                    wb_data_s[e] = wb_data_i[p*DATA_W +: DATA_W];
                    wb_ex_s[e]   = wb_ex_i[p];
                end else begin
                    wb_hit_s[e]  = wb_hit_s[e];
                end
            end
        end
    end

    // Commit outputs: head entry contents, optionally bypassed from writeback.
    always_comb begin
        commit_valid_o = (cnt_q != '0) && done_q[head_q];
        commit_rd_o    = rd_q[head_q];
        commit_data_o  = data_q[head_q];
        commit_ex_o    = ex_q[head_q];
`ifdef SCOREBOARD_WB_BYPASS_EN
        // A non-zero count guarantees the head entry is issued.
        if ((cnt_q != '0) && !done_q[head_q] && wb_hit_s[head_q]) begin
            commit_valid_o = 1'b1;
            commit_data_o  = wb_data_s[head_q];
            commit_ex_o    = wb_ex_s[head_q];
        end else begin
            commit_valid_o = commit_valid_o;
        end
`endif
    end

    // Next-state: writeback, issue, commit, then flush overriding everything.
    always_comb begin
        tail_d = tail_q;
        head_d = head_q;
        cnt_d  = cnt_q;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            issued_d[e] = issued_q[e];
            done_d[e]   = done_q[e];
            rd_d[e]     = rd_q[e];
            data_d[e]   = data_q[e];
            ex_d[e]     = ex_q[e];
            // The entry allocated this cycle is not yet issued, so a
            // same-cycle writeback to it falls through here.
            if (wb_hit_s[e] && issued_q[e]) begin
                done_d[e] = 1'b1;
                data_d[e] = wb_data_s[e];
                ex_d[e]   = wb_ex_s[e];
            end else begin
                done_d[e] = done_d[e];
            end
        end

        if (issue_acc_s) begin
            issued_d[tail_q] = 1'b1;
            done_d[tail_q]   = 1'b0;
            rd_d[tail_q]     = issue_rd_i;
            tail_d           = tail_q + TID_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (commit_fire_s) begin
            issued_d[head_q] = 1'b0;
            done_d[head_q]   = 1'b0;
            rd_d[head_q]     = 5'd0;
            data_d[head_q]   = '0;
            ex_d[head_q]     = 1'b0;
            head_d           = head_q + TID_W'(1);
        end else begin
            head_d = head_q;
        end

        case ({issue_acc_s, commit_fire_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (flush_i) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                issued_d[e] = 1'b0;
                done_d[e]   = 1'b0;
            end
            tail_d = '0;
            head_d = '0;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State registers; reset also clears entry storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tail_q <= '0;
            head_q <= '0;
            cnt_q  <= '0;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                issued_q[e] <= 1'b0;
                done_q[e]   <= 1'b0;
                rd_q[e]     <= 5'd0;
                data_q[e]   <= '0;
                ex_q[e]     <= 1'b0;
            end
        end else begin
            tail_q <= tail_d;
            head_q <= head_d;
            cnt_q  <= cnt_d;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                issued_q[e] <= issued_d[e];
                done_q[e]   <= done_d[e];
                rd_q[e]     <= rd_d[e];
                data_q[e]   <= data_d[e];
                ex_q[e]     <= ex_d[e];
            end
        end
    end

endmodule
